uart_boot_loader: RTL and testbench

Boot-time controller that sits between the UART receiver and the Hack instruction ROM write port. It holds the Hack CPU in reset, accepts a framed program image over UART, and writes each 16-bit instruction into ROM. It then releases the CPU, or boots the resident image if no host shows up. After release it ignores all UART traffic, so the running program owns the serial stream.

---
 rtl/hack_boot_pkg.sv | 30 +++
 rtl/boot_timeout_timer.sv | 31 +++
 rtl/uart_boot_loader.sv | 201 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_boot_pkg.sv
// Shared types and constants for the Hack UART boot loader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hack_boot_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_LEN_HI    = 3'd1,
    ST_LEN_LO    = 3'd2,
    ST_DATA_HI   = 3'd3,
    ST_DATA_LO   = 3'd4,
    ST_CSUM      = 3'd5,
    ST_RUN       = 3'd6,
    ST_ERROR     = 3'd7
  } boot_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_CSUM    = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // True while a frame is being received (LEN_HI through CSUM).
  function automatic logic in_frame(input boot_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/boot_timeout_timer.sv
// Inactivity timer: pulses expired once TIMEOUT_CLKS cycles pass without a restart.
// Latency: expired is combinational from the count register, high in the cycle count hits TIMEOUT_CLKS-1.
// Backpressure: none; restart always wins, disable clears the count.
module boot_timeout_timer #(
  parameter int TIMEOUT_CLKS = 50_000_000
) (
  input  logic i_CLK,
  input  logic i_RESET_n,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);

  logic [CW-1:0] count_q;

  assign expired = enable && (count_q == CW'(TIMEOUT_CLKS - 1));

  // Count idle cycles; any restart or a disabled timer returns to zero.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      count_q <= '0;
    end else if (restart || !enable || expired) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over UART, writes it into Hack ROM, then releases the CPU.
// Latency: ROM write pulses one cycle after the DATA_LO strobe; status outputs change with the state.
// Backpressure: none; every strobe is consumed in its own cycle, traffic is ignored after RUN/ERROR.
module uart_boot_loader
  import hack_boot_pkg::*;
#(
  parameter int         ADDR_W       = 15,
  parameter int         MAX_WORDS    = 32768,
  parameter int         TIMEOUT_CLKS = 50_000_000,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic              i_CLK,
  input  logic              i_RESET_n,
  input  logic [7:0]        i_RX_Byte,
  input  logic              i_RX_DV,
  output logic [ADDR_W-1:0] o_ROM_Addr,
  output logic [15:0]       o_ROM_Data,
  output logic              o_ROM_WE,
  output logic              o_CPU_Reset,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [1:0]        o_Error
);

  boot_state_t state_q, state_d;

  logic [15:0]       len_q;
  logic [15:0]       word_cnt_q;
  logic [7:0]        csum_q;
  logic [7:0]        data_hi_q;
  logic [ADDR_W-1:0] addr_q;

  logic [15:0] rom_data_q, rom_data_d;
  logic        rom_we_q, rom_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [1:0]  err_q, err_d;

  logic        sync_hit;
  logic        frame_strobe;
  logic [15:0] len_n;
  logic        len_bad;
  logic        last_word;

  logic timer_restart;
  logic timer_en;
  logic timer_expired;

  assign sync_hit     = i_RX_DV && (state_q == ST_WAIT_SYNC) && (i_RX_Byte == SYNC_BYTE);
  assign frame_strobe = i_RX_DV && in_frame(state_q);
  // Full length as it will be once the LEN_LO byte lands.
  assign len_n        = {len_q[15:8], i_RX_Byte};
  assign len_bad      = (len_n == 16'd0) || (32'(len_n) > 32'(MAX_WORDS));
  assign last_word    = ((word_cnt_q + 16'd1) == len_q);

  // Timer stops in the terminal states and restarts on any accepted byte or state change.
  assign timer_en      = (state_q != ST_RUN) && (state_q != ST_ERROR);
  assign timer_restart = frame_strobe || (state_d != state_q);

  boot_timeout_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .i_CLK    (i_CLK),
    .i_RESET_n(i_RESET_n),
    .restart  (timer_restart),
    .enable   (timer_en),
    .expired  (timer_expired)
  );

  // State register.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q <= ST_WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a received byte takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SYNC: begin
        if (sync_hit)           state_d = ST_LEN_HI;
        else if (timer_expired) state_d = ST_RUN;
      end
      ST_LEN_HI: begin
        if (i_RX_DV)            state_d = ST_LEN_LO;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_LEN_LO: begin
        if (i_RX_DV)            state_d = len_bad ? ST_ERROR : ST_DATA_HI;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_DATA_HI: begin
        if (i_RX_DV)            state_d = ST_DATA_LO;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_DATA_LO: begin
        if (i_RX_DV)            state_d = last_word ? ST_CSUM : ST_DATA_HI;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_CSUM: begin
        if (i_RX_DV)            state_d = (i_RX_Byte == csum_q) ? ST_RUN : ST_ERROR;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_RUN:   state_d = ST_RUN;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_WAIT_SYNC;
    endcase
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    rom_we_d   = (state_q == ST_DATA_LO) && i_RX_DV;
    rom_data_d = rom_we_d ? {data_hi_q, i_RX_Byte} : rom_data_q;
    busy_d     = in_frame(state_d);
    cpu_rst_d  = (state_q != ST_RUN);
    done_d     = done_q;
    err_d      = err_q;
    if ((state_q == ST_CSUM) && (state_d == ST_RUN)) begin
      done_d = 1'b1;
    end
    if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
      if (!i_RX_DV)                err_d = ERR_TIMEOUT;
      else if (state_q == ST_LEN_LO) err_d = ERR_LEN;
      else                         err_d = ERR_CSUM;
    end
  end

  // Output registers; the CPU is held in reset until RUN has been reached.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      rom_we_q   <= 1'b0;
      rom_data_q <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
      cpu_rst_q  <= 1'b1;
    end else begin
      rom_we_q   <= rom_we_d;
      rom_data_q <= rom_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Frame datapath: length, high byte, checksum, word count and write address.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      len_q      <= 16'd0;
      word_cnt_q <= 16'd0;
      csum_q     <= 8'd0;
      data_hi_q  <= 8'd0;
      addr_q     <= '0;
    end else begin
      if (sync_hit) begin
        csum_q     <= 8'd0;
        word_cnt_q <= 16'd0;
        addr_q     <= '0;
      end else if (frame_strobe) begin
        case (state_q)
          ST_LEN_HI: begin
            len_q[15:8] <= i_RX_Byte;
            csum_q      <= csum_q + i_RX_Byte;
          end
          ST_LEN_LO: begin
            len_q[7:0] <= i_RX_Byte;
            csum_q     <= csum_q + i_RX_Byte;
          end
          ST_DATA_HI: begin
            data_hi_q <= i_RX_Byte;
            csum_q    <= csum_q + i_RX_Byte;
          end
          ST_DATA_LO: begin
            word_cnt_q <= word_cnt_q + 16'd1;
            csum_q     <= csum_q + i_RX_Byte;
          end
          default: begin
          end
        endcase
      end
      // Address advances once the write it belongs to has been presented.
      if (rom_we_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign o_ROM_Addr  = addr_q;
  assign o_ROM_Data  = rom_data_q;
  assign o_ROM_WE    = rom_we_q;
  assign o_CPU_Reset = cpu_rst_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Error     = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a 1000-cycle timeout.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: none.
module tb_uart_boot_loader;

  logic        i_CLK = 1'b0;
  logic        i_RESET_n;
  logic [7:0]  i_RX_Byte;
  logic        i_RX_DV;
  logic [14:0] o_ROM_Addr;
  logic [15:0] o_ROM_Data;
  logic        o_ROM_WE;
  logic        o_CPU_Reset;
  logic        o_Busy;
  logic        o_Done;
  logic [1:0]  o_Error;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int base;
  int n;
  int bad;

  uart_boot_loader #(
    .ADDR_W      (15),
    .MAX_WORDS   (32768),
    .TIMEOUT_CLKS(1000),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .i_CLK      (i_CLK),
    .i_RESET_n  (i_RESET_n),
    .i_RX_Byte  (i_RX_Byte),
    .i_RX_DV    (i_RX_DV),
    .o_ROM_Addr (o_ROM_Addr),
    .o_ROM_Data (o_ROM_Data),
    .o_ROM_WE   (o_ROM_WE),
    .o_CPU_Reset(o_CPU_Reset),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Error    (o_Error)
  );

  always #5 i_CLK = ~i_CLK;

  // Count ROM write pulses, sampled on the falling edge.
  always @(negedge i_CLK) begin
    if (o_ROM_WE === 1'b1) we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; called on a falling edge, returns on the next one.
  task automatic send(input logic [7:0] b);
    i_RX_Byte = b;
    i_RX_DV   = 1'b1;
    @(negedge i_CLK);
    i_RX_DV   = 1'b0;
  endtask

  task automatic do_reset();
    i_RESET_n = 1'b0;
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
    repeat (2) @(negedge i_CLK);
    i_RESET_n = 1'b1;
  endtask

  initial begin
    i_RESET_n = 1'b0;
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
    repeat (2) @(negedge i_CLK);
    #1;
    chk("rst_cpu_reset", o_CPU_Reset, 1);
    chk("rst_done",      o_Done, 0);
    chk("rst_error",     o_Error, 0);
    chk("rst_busy",      o_Busy, 0);
    chk("rst_we",        o_ROM_WE, 0);
    chk("rst_addr",      o_ROM_Addr, 0);
    chk("rst_data",      o_ROM_Data, 0);
    @(negedge i_CLK);
    i_RESET_n = 1'b1;

    // Happy path, bytes sent back to back (the AB strobe lands in the first WE cycle).
    @(negedge i_CLK);
    #1 base = we_cnt;
    send(8'h41);
    send(8'hA5);
    chk("hp_busy", o_Busy, 1);
    send(8'h00);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    chk("hp_we0",   o_ROM_WE, 1);
    chk("hp_addr0", o_ROM_Addr, 0);
    chk("hp_data0", o_ROM_Data, 16'h1234);
    send(8'hAB);
    send(8'hCD);
    chk("hp_we1",   o_ROM_WE, 1);
    chk("hp_addr1", o_ROM_Addr, 1);
    chk("hp_data1", o_ROM_Data, 16'hABCD);
    send(8'hC0);
    chk("hp_done",       o_Done, 1);
    chk("hp_error",      o_Error, 0);
    chk("hp_busy_end",   o_Busy, 0);
    chk("hp_cpu_held",   o_CPU_Reset, 1);
    @(negedge i_CLK);
    chk("hp_cpu_release", o_CPU_Reset, 0);
    #1 chk("hp_we_count", we_cnt - base, 2);
    base = we_cnt;
    @(negedge i_CLK);
    send(8'h41);
    repeat (3) @(negedge i_CLK);
    #1 chk("hp_ignore_after_run", we_cnt - base, 0);

    // No traffic: resident image boots after the timeout.
    do_reset();
    base = we_cnt;
    n = 0;
    while (o_CPU_Reset !== 1'b0 && n < 3000) begin
      @(negedge i_CLK);
      n++;
    end
    chk("idle_release_cycles", n, 1001);
    chk("idle_done", o_Done, 0);
    chk("idle_error", o_Error, 0);
    #1 chk("idle_we_count", we_cnt - base, 0);

    // Bad checksum.
    do_reset();
    #1 base = we_cnt;
    @(negedge i_CLK);
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
    send(8'h34); send(8'hAB); send(8'hCD); send(8'hC1);
    chk("csum_error", o_Error, 2'b11);
    chk("csum_done",  o_Done, 0);
    @(negedge i_CLK);
    #1 chk("csum_we_count", we_cnt - base, 2);
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge i_CLK);
      if (o_CPU_Reset !== 1'b1) bad++;
    end
    chk("csum_cpu_held", bad, 0);

    // Zero length.
    do_reset();
    #1 base = we_cnt;
    @(negedge i_CLK);
    send(8'hA5); send(8'h00); send(8'h00);
    chk("zlen_error", o_Error, 2'b10);
    chk("zlen_busy",  o_Busy, 0);
    repeat (2) @(negedge i_CLK);
    #1 chk("zlen_we_count", we_cnt - base, 0);

    // Stall after one data byte.
    do_reset();
    #1 base = we_cnt;
    @(negedge i_CLK);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
    n = 0;
    while (o_Error !== 2'b01 && n < 3000) begin
      @(negedge i_CLK);
      n++;
    end
    chk("stall_timeout_cycles", n, 1000);
    chk("stall_cpu_held", o_CPU_Reset, 1);
    #1 chk("stall_we_count", we_cnt - base, 0);

    // Reset mid-frame, then a full frame.
    do_reset();
    @(negedge i_CLK);
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    i_RESET_n = 1'b0;
    #1;
    chk("mid_we",   o_ROM_WE, 0);
    chk("mid_addr", o_ROM_Addr, 0);
    chk("mid_data", o_ROM_Data, 0);
    chk("mid_busy", o_Busy, 0);
    chk("mid_cpu",  o_CPU_Reset, 1);
    @(negedge i_CLK);
    i_RESET_n = 1'b1;
    @(negedge i_CLK);
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    chk("mid_re_we0",   o_ROM_WE, 1);
    chk("mid_re_addr0", o_ROM_Addr, 0);
    send(8'hAB); send(8'hCD); send(8'hC0);
    chk("mid_re_done",  o_Done, 1);
    chk("mid_re_error", o_Error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
